debounce_pulse: RTL and testbench

Conditioning stage that sits directly upstream of the enable-gated D flip-flop. It takes a raw, asynchronous push-button or switch input and synchronizes it to `clk`. It filters contact bounce with a stability counter and produces a clean level (`level`) to drive the flip-flop's `D`. It also produces single-cycle edge pulses (`rise`, `fall`) to drive its `enable`, so a flip-flop captures exactly once per physical press.

---
 rtl/debounce_pulse.sv | 137 +++++++++++++
 tb/tb_debounce_pulse.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/debounce_pulse.sv
// debounce_pulse
//
// Cleans up a raw push-button or switch input before it reaches an
// enable-gated D flip-flop. The input is first brought into the clk domain
// through a two-flop synchronizer. A stability counter then filters contact
// bounce. The block produces a debounced level plus single-cycle rise/fall
// pulses, so a downstream flip-flop captures exactly once per press.
//
// Optional feature: define DEBOUNCE_TOGGLE_EN to add the `toggle` output.
// It flips once for every debounced press.
//
// Parameters:
//   STABLE_CYCLES  consecutive clk edges the synchronized input must differ
//                  from `level` before `level` follows it (2 .. 2^CNT_W-1)
//   CNT_W          width of the stability counter
//
// Ports:
//   clk      in   system clock, all state changes on the rising edge
//   reset    in   synchronous active-high reset
//   btn_in   in   raw asynchronous button/switch input
//   level    out  debounced registered level
//   rise     out  one-cycle pulse when level goes 0->1
//   fall     out  one-cycle pulse when level goes 1->0
//   toggle   out  (DEBOUNCE_TOGGLE_EN only) inverts once per rise pulse

module debounce_pulse #(
    parameter int STABLE_CYCLES = 50000,
    parameter int CNT_W         = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic level,
    output logic rise,
`ifdef DEBOUNCE_TOGGLE_EN
    output logic fall,
    output logic toggle
`else
    output logic fall
`endif
);

    localparam logic [1:0] IDLE_LOW  = 2'd0;
    localparam logic [1:0] WAIT_HIGH = 2'd1;
    localparam logic [1:0] IDLE_HIGH = 2'd2;
    localparam logic [1:0] WAIT_LOW  = 2'd3;

    // The last count value before the level is allowed to change. Because
    // counting starts at 1 on the first differing sample, reaching this value
    // while the input still differs means STABLE_CYCLES consecutive samples.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;

    // Synchronizer, debounce FSM and registered edge pulses.
    // The WAIT states fall back to their IDLE state on any sample that
    // agrees with the current level. A single-cycle glitch therefore throws
    // away the count collected so far. The rise/fall pulses default low
    // every cycle, so each one lasts only the cycle after the level change.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            state <= IDLE_LOW;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
            rise  <= 1'b0;
            fall  <= 1'b0;
            case (state)
                IDLE_LOW: begin
                    if (sync2) begin
                        state <= WAIT_HIGH;
                        cnt   <= CNT_W'(1);
                    end
                end
                WAIT_HIGH: begin
                    if (!sync2) begin
                        state <= IDLE_LOW;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE_HIGH;
                        level <= 1'b1;
                        rise  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                IDLE_HIGH: begin
                    if (!sync2) begin
                        state <= WAIT_LOW;
                        cnt   <= CNT_W'(1);
                    end
                end
                WAIT_LOW: begin
                    if (sync2) begin
                        state <= IDLE_HIGH;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE_LOW;
                        level <= 1'b0;
                        fall  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE_LOW;
                    cnt   <= '0;
                    level <= 1'b0;
                end
            endcase
        end
    end

`ifdef DEBOUNCE_TOGGLE_EN
    // The toggle flips on the edge where the rise pulse is high. That puts
    // it one cycle behind the level change, and releases never affect it.
    always_ff @(posedge clk) begin
        if (reset) begin
            toggle <= 1'b0;
        end else if (rise) begin
            toggle <= ~toggle;
        end
    end
`endif

endmodule

// File: tb/tb_debounce_pulse.sv
// tb_debounce_pulse
//
// Drives debounce_pulse (STABLE_CYCLES=4, CNT_W=3) through directed
// scenarios and then randomized button activity. Outputs are compared every
// cycle against a reference model. The model treats the synchronizer as a
// two-sample delay line and changes the level after a run of STABLE_CYCLES
// consecutive delayed samples that disagree with the current level.

module tb_debounce_pulse;

    localparam int STABLE = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_in = 1'b0;
    logic level;
    logic rise;
    logic fall;
`ifdef DEBOUNCE_TOGGLE_EN
    logic toggle;
`endif

    int passCount  = 0;
    int totalCount = 0;

    // Reference model state
    logic delayLine[$];
    logic mLevel  = 1'b0;
    logic mRise   = 1'b0;
    logic mFall   = 1'b0;
    logic mToggle = 1'b0;
    int   runLen  = 0;
    int   riseSeen = 0;

    debounce_pulse #(
        .STABLE_CYCLES(STABLE),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_in(btn_in),
        .level(level),
        .rise(rise),
`ifdef DEBOUNCE_TOGGLE_EN
        .fall(fall),
        .toggle(toggle)
`else
        .fall(fall)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        totalCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    endtask

    // Advances the model by one rising edge, using the inputs that were
    // present at that edge.
    task automatic modelEdge(input logic r, input logic b);
        logic obs;
        if (r) begin
            delayLine = {1'b0, 1'b0};
            mLevel  = 1'b0;
            mRise   = 1'b0;
            mFall   = 1'b0;
            mToggle = 1'b0;
            runLen  = 0;
        end else begin
            if (mRise) mToggle = ~mToggle;
            obs = delayLine.pop_front();
            delayLine.push_back(b);
            mRise = 1'b0;
            mFall = 1'b0;
            if (obs != mLevel) begin
                runLen++;
                if (runLen == STABLE) begin
                    mLevel = ~mLevel;
                    mRise  = mLevel;
                    mFall  = ~mLevel;
                    runLen = 0;
                end
            end else begin
                runLen = 0;
            end
        end
    endtask

    // Applies one cycle of inputs, then samples the outputs 1ns after the
    // edge and compares them with the model.
    task automatic applyStimulus(input logic r, input logic b);
        reset  = r;
        btn_in = b;
        @(posedge clk);
        #1;
        modelEdge(r, b);
        checkOutput("level", level, mLevel);
        checkOutput("rise", rise, mRise);
        checkOutput("fall", fall, mFall);
        if (rise === 1'b1 && fall === 1'b1) checkOutput("rise_fall_exclusive", 1'b1, 1'b0);
        if (rise === 1'b1) riseSeen++;
`ifdef DEBOUNCE_TOGGLE_EN
        checkOutput("toggle", toggle, mToggle);
`endif
    endtask

    initial begin
        int holdLen;
        logic nextBtn;
        int risesBefore;
        logic [4:0] bounce;
        delayLine = {1'b0, 1'b0};

        // Reset with the button low, then idle
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
        checkOutput("reset_level", level, 1'b0);
        checkOutput("reset_rise", rise, 1'b0);
        checkOutput("reset_fall", fall, 1'b0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0);
        checkOutput("idle_no_rise", 1'(riseSeen), 1'b0);

        // Clean press: rise on the sixth edge counted from the press
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1);
            if (i == 4) checkOutput("press_rise_early", rise, 1'b0);
            if (i == 5) begin
                checkOutput("press_rise_latency", rise, 1'b1);
                checkOutput("press_level", level, 1'b1);
            end
            if (i == 6) checkOutput("press_rise_width", rise, 1'b0);
        end

        // Release: fall on the sixth edge after the release
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0);
            if (i == 5) begin
                checkOutput("release_fall_latency", fall, 1'b1);
                checkOutput("release_level", level, 1'b0);
            end
            if (i == 6) checkOutput("release_fall_width", fall, 1'b0);
        end

        // Bounce 1,0,1,1,0 then held high: one rise, six edges after the last 0->1
        risesBefore = riseSeen;
        bounce = 5'b01101;
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, bounce[i]);
        checkOutput("bounce_no_rise", 1'(riseSeen - risesBefore), 1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1);
            if (i == 5) checkOutput("bounce_rise_latency", rise, 1'b1);
        end
        checkOutput("bounce_single_rise", 1'(riseSeen - risesBefore), 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0);

        // Reset two cycles into WAIT_HIGH, button held high throughout
        risesBefore = riseSeen;
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1);
        checkOutput("midreset_no_rise", 1'(riseSeen - risesBefore), 1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1);
            if (i == 5) checkOutput("midreset_rise_latency", rise, 1'b1);
        end
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0);

        // Toggle sequence: three clean press/release cycles after a reset
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0);
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b1);
            for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b0);
`ifdef DEBOUNCE_TOGGLE_EN
            checkOutput("toggle_sequence", toggle, (p % 2 == 0) ? 1'b1 : 1'b0);
`endif
        end

        // Randomized bouncing with occasional resets
        nextBtn = 1'b0;
        for (int n = 0; n < 120; n++) begin
            nextBtn = ~nextBtn;
            holdLen = $urandom_range(1, 9);
            for (int i = 0; i < holdLen; i++) begin
                applyStimulus(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0, nextBtn);
            end
        end

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
